// File: rtl/data_mem_pkg.sv
// data_mem shared constants and types.
// Default geometry plus the stored word type.
package data_mem_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 64;
  localparam int DEPTH_DEF  = 64;

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/data_mem_addr_dec.sv
// data_mem address decoder: byte address -> word index, in-range flag,
// and (with DATA_MEM_ALIGN_CHK_EN) a misaligned-access flag.
// Ports: address in; idx, in_range out; mem_read/mem_write in and
// misaligned out only when DATA_MEM_ALIGN_CHK_EN is defined.
module data_mem_addr_dec
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_W-1:0] address,
`ifdef DATA_MEM_ALIGN_CHK_EN
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              misaligned,
`endif
  output logic [IDX_W-1:0]  idx,
  output logic              in_range
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 8);

  assign idx = address[IDX_W+2:3];

  // Full-width compare: every upper bit takes part in the range test.
  assign in_range = address < LIMIT;

`ifdef DATA_MEM_ALIGN_CHK_EN
  assign misaligned = (mem_read | mem_write)
                    & (address[2:0] != 3'd0);
`endif

endmodule

// File: rtl/data_mem.sv
// data_mem: DEPTH x DATA_W doubleword data memory, byte addressed,
// combinational read, async active-high reset clears every word.
// Ports: clk, reset, address, wrt_data, mem_write, mem_read in;
// read_data out; misaligned out with DATA_MEM_ALIGN_CHK_EN defined.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic              mem_write,
  input  logic              mem_read,
`ifdef DATA_MEM_ALIGN_CHK_EN
  output logic              misaligned,
`endif
  output logic [DATA_W-1:0] read_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              ok;
  logic              wr_en;

  data_mem_addr_dec #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_dec (
    .address    (address),
`ifdef DATA_MEM_ALIGN_CHK_EN
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .misaligned (misaligned),
`endif
    .idx        (idx),
    .in_range   (in_range)
  );

`ifdef DATA_MEM_ALIGN_CHK_EN
  assign ok = in_range & ~misaligned;
`else
  assign ok = in_range;
`endif

  assign wr_en = mem_write & ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wrt_data;
    end
  end

  // No write-data bypass: a same-word write shows up only after the edge.
  assign read_data = (mem_read & ok & ~reset) ? mem[idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized check of data_mem against an array model.
// Model works on plain byte addresses (addr/8, addr<DEPTH*8).
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam logic [63:0] LIMIT = 64'(DEPTH * 8);

  logic        clk;
  logic        reset;
  logic [63:0] address;
  logic [63:0] wrt_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] read_data;
`ifdef DATA_MEM_ALIGN_CHK_EN
  logic        misaligned;
`endif

  word_t model [DEPTH];
  int    n_chk;
  int    n_err;

  data_mem dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .wrt_data   (wrt_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
`ifdef DATA_MEM_ALIGN_CHK_EN
    .misaligned (misaligned),
`endif
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit aligned_ok(input logic [63:0] a);
`ifdef DATA_MEM_ALIGN_CHK_EN
    return (a % 8) == 0;
`else
    return a == a;
`endif
  endfunction

  function automatic word_t exp_rd();
    if (!mem_read || reset) return '0;
    if (address >= LIMIT) return '0;
    if (!aligned_ok(address)) return '0;
    return model[int'(address / 8)];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic drive(input bit we, input bit re,
                       input logic [63:0] a, input logic [63:0] d);
    mem_write = we;
    mem_read  = re;
    address   = a;
    wrt_data  = d;
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, "_pre"}, read_data, exp_rd());
`ifdef DATA_MEM_ALIGN_CHK_EN
    chk({tag, "_mis"}, 64'(misaligned),
        64'((mem_read || mem_write) && (address % 8) != 0));
`endif
    if (mem_write && !reset && address < LIMIT && aligned_ok(address))
      model[int'(address / 8)] = wrt_data;
    @(posedge clk);
    #1;
    chk({tag, "_post"}, read_data, exp_rd());
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 64'(i * 8), '0);
      #1;
      chk(tag, read_data, model[i]);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    int r;
    logic [63:0] a;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      a = 64'($urandom_range(0, DEPTH - 1) * 8);
`ifdef DATA_MEM_ALIGN_CHK_EN
      if ($urandom_range(0, 3) == 0) a += 64'($urandom_range(0, 7));
`else
      a += 64'($urandom_range(0, 7));
`endif
    end else if (r < 9) begin
      a = LIMIT + 64'($urandom_range(0, 63));
    end else begin
      a = {$urandom(), $urandom()};
    end
    return a;
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    model_clear();
    reset = 1'b1;
    drive(1'b0, 1'b1, '0, '0);
    #12;
    chk("rst_hold", read_data, '0);
    @(negedge clk);
    reset = 1'b0;
    scan("rst_scan");

    drive(1'b1, 1'b1, 64'd0, 64'd916);
    step("w916");
    chk("w916_val", read_data, 64'd916);
    drive(1'b0, 1'b1, 64'd8, '0);
    #1;
    chk("w916_a8", read_data, '0);

    drive(1'b1, 1'b1, 64'd8, 64'hDEAD_BEEF);
    step("wbeef");
    drive(1'b1, 1'b1, 64'd0, 64'd1);
    step("w1");
    drive(1'b0, 1'b1, 64'd8, '0);
    #1;
    chk("rd_beef", read_data, 64'hDEAD_BEEF);
    drive(1'b0, 1'b1, 64'd0, '0);
    #1;
    chk("rd_1", read_data, 64'd1);
    drive(1'b0, 1'b0, 64'd0, '0);
    #1;
    chk("rd_off", read_data, '0);

    drive(1'b1, 1'b1, LIMIT, 64'd5);
    step("w_oor");
    chk("rd_oor", read_data, '0);
    scan("oor_scan");

    drive(1'b1, 1'b1, 64'd0, 64'd916);
    step("pre_rst");
    drive(1'b1, 1'b1, 64'd0, 64'd123);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_async", read_data, '0);
    @(posedge clk);
    #1;
    chk("rst_edge", read_data, '0);
    mem_write = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rel", read_data, '0);
    scan("rst_scan2");
    drive(1'b1, 1'b1, 64'd0, 64'd77);
    step("first_wr");
    chk("first_val", read_data, 64'd77);

`ifdef DATA_MEM_ALIGN_CHK_EN
    drive(1'b1, 1'b1, 64'd3, 64'd7);
    step("mis_wr");
    chk("mis_flag", 64'(misaligned), 64'd1);
    drive(1'b0, 1'b1, 64'd0, '0);
    #1;
    chk("mis_w0", read_data, 64'd77);
`endif

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            rnd_addr(), {$urandom(), $urandom()});
      if ($urandom_range(0, 24) == 0) begin
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rnd_rst", read_data, '0);
        reset = 1'b0;
      end
      step("rnd");
    end
    scan("final_scan");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
